// File: rtl/gb_pkg.sv
// Shared LR35902 encodings: decode access classes, sequencer states, register fields.
package gb_pkg;

  localparam int unsigned CLS_W   = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [CLS_W-1:0] CLS_NONE   = 3'd0;
  localparam logic [CLS_W-1:0] CLS_IMM8   = 3'd1;
  localparam logic [CLS_W-1:0] CLS_IMM16  = 3'd2;
  localparam logic [CLS_W-1:0] CLS_RD_HL  = 3'd3;
  localparam logic [CLS_W-1:0] CLS_WR_HL  = 3'd4;
  localparam logic [CLS_W-1:0] CLS_HALT   = 3'd5;
  localparam logic [CLS_W-1:0] CLS_PREFIX = 3'd6;
  localparam logic [CLS_W-1:0] CLS_RMW_HL = 3'd7;

  localparam logic [STATE_W-1:0] S_FETCH    = 3'd0;
  localparam logic [STATE_W-1:0] S_CB_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_IMM_LO   = 3'd2;
  localparam logic [STATE_W-1:0] S_IMM_HI   = 3'd3;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 3'd4;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 3'd5;
  localparam logic [STATE_W-1:0] S_INTERNAL = 3'd6;
  localparam logic [STATE_W-1:0] S_HALTED   = 3'd7;

  localparam logic [2:0] REG_B   = 3'b000;
  localparam logic [2:0] REG_C   = 3'b001;
  localparam logic [2:0] REG_D   = 3'b010;
  localparam logic [2:0] REG_E   = 3'b011;
  localparam logic [2:0] REG_H   = 3'b100;
  localparam logic [2:0] REG_L   = 3'b101;
  localparam logic [2:0] REG_MHL = 3'b110;
  localparam logic [2:0] REG_A   = 3'b111;

endpackage

// File: rtl/cpu_sequencer_tstate_counter.sv
// T-state counter within an M-cycle; holds on the bus T-state while an access is stretched.
module tstate_counter #(
  parameter int unsigned T_PER_M = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       access,
  input  logic       mem_wait,
  output logic [1:0] tstate,
  output logic       sample_c,
  output logic       m_end
);

  localparam logic [1:0] T_BUS  = 2'(T_PER_M - 2);
  localparam logic [1:0] T_LAST = 2'(T_PER_M - 1);

  logic hold_c;

  always_comb begin
    hold_c   = access && mem_wait && (tstate == T_BUS);
    sample_c = (tstate == T_BUS) && !hold_c;
    m_end    = (tstate == T_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tstate <= 2'd0;
    else if (!hold_c) tstate <= tstate + 2'd1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Machine-cycle sequencer: fetch / operand / (HL) access / HALT flow around decode.
module cpu_sequencer
  import gb_pkg::*;
#(
  parameter int unsigned T_PER_M = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_wait,
  input  logic [15:0] pc,
  input  logic [15:0] hl,
  output logic        pc_inc,
  output logic [7:0]  ir,
  output logic        cb_prefix,
  input  logic [2:0]  dec_class,
  input  logic [1:0]  dec_internal,
  output logic [15:0] imm,
  output logic        exec_strobe,
  output logic        halted,
  input  logic        irq_pending,
  output logic [1:0]  tstate,
  output logic [2:0]  mcycle
);

  logic [STATE_W-1:0] state_q, state_d, tail_c;
  logic [CLS_W-1:0]   cls_q, cls_d, eff_cls_c;
  logic [1:0]         icnt_q, icnt_d;
  logic [2:0]         mcyc_q, mcyc_d;
  logic               fetch_st_c, pcinc_st_c, rd_st_c, wr_st_c, access_c;
  logic               sample_c, m_end_c;

  always_comb begin
    fetch_st_c = (state_q == S_FETCH) || (state_q == S_CB_FETCH);
    pcinc_st_c = fetch_st_c || (state_q == S_IMM_LO) || (state_q == S_IMM_HI);
    rd_st_c    = pcinc_st_c || (state_q == S_MEM_RD);
    wr_st_c    = (state_q == S_MEM_WR);
    access_c   = rd_st_c || wr_st_c;
  end

  tstate_counter #(.T_PER_M(T_PER_M)) u_tstate (
    .clk      (clk),
    .rst_n    (rst_n),
    .access   (access_c),
    .mem_wait (mem_wait),
    .tstate   (tstate),
    .sample_c (sample_c),
    .m_end    (m_end_c)
  );

  // Address must track pc/hl in the same T-state, so it is decoded from state.
  always_comb begin
    mem_addr = 16'h0000;
    if (pcinc_st_c) mem_addr = pc;
    else if ((state_q == S_MEM_RD) || wr_st_c) mem_addr = hl;
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    icnt_d      = icnt_q;
    mcyc_d      = mcyc_q;
    exec_strobe = 1'b0;
    tail_c      = (icnt_q == 2'd0) ? S_FETCH : S_INTERNAL;
    eff_cls_c   = dec_class;
    // A second prefix or HALT on the CB page has no meaning; run it as a plain op.
    if ((state_q == S_CB_FETCH) && ((dec_class == CLS_PREFIX) || (dec_class == CLS_HALT)))
      eff_cls_c = CLS_NONE;
    if (m_end_c) begin
      mcyc_d = mcyc_q + 3'd1;
      case (state_q)
        S_FETCH, S_CB_FETCH: begin
          cls_d  = eff_cls_c;
          icnt_d = dec_internal;
          case (eff_cls_c)
            CLS_IMM8, CLS_IMM16:   state_d = S_IMM_LO;
            CLS_RD_HL, CLS_RMW_HL: state_d = S_MEM_RD;
            CLS_WR_HL:             state_d = S_MEM_WR;
            CLS_HALT:              state_d = S_HALTED;
            CLS_PREFIX:            state_d = S_CB_FETCH;
            default:               state_d = (dec_internal == 2'd0) ? S_FETCH : S_INTERNAL;
          endcase
        end
        S_IMM_LO:  state_d = (cls_q == CLS_IMM16) ? S_IMM_HI : tail_c;
        S_MEM_RD:  state_d = (cls_q == CLS_RMW_HL) ? S_MEM_WR : tail_c;
        S_IMM_HI, S_MEM_WR: state_d = tail_c;
        S_INTERNAL: begin
          icnt_d  = icnt_q - 2'd1;
          state_d = (icnt_q <= 2'd1) ? S_FETCH : S_INTERNAL;
        end
        S_HALTED:  state_d = irq_pending ? S_FETCH : S_HALTED;
        default:   state_d = S_FETCH;
      endcase
      if ((state_d == S_FETCH) || (state_d == S_HALTED)) begin
        mcyc_d      = 3'd0;
        exec_strobe = (state_q != S_HALTED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NONE;
      icnt_q    <= 2'd0;
      mcyc_q    <= 3'd0;
      ir        <= 8'h00;
      cb_prefix <= 1'b0;
      imm       <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      pc_inc    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      icnt_q  <= icnt_d;
      mcyc_q  <= mcyc_d;
      pc_inc  <= sample_c && pcinc_st_c;
      // Strobes rise entering T1 and fall on the edge that samples read data.
      if (tstate == 2'd0) begin
        mem_rd <= rd_st_c;
        mem_wr <= wr_st_c;
      end else if (sample_c) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
      end
      if (sample_c) begin
        case (state_q)
          S_FETCH:    begin ir <= mem_rdata; cb_prefix <= 1'b0; end
          S_CB_FETCH: begin ir <= mem_rdata; cb_prefix <= 1'b1; end
          S_IMM_LO: begin
            imm[7:0] <= mem_rdata;
            if (cls_q == CLS_IMM8) imm[15:8] <= 8'h00;
          end
          S_IMM_HI:   imm[15:8] <= mem_rdata;
          S_MEM_RD:   imm[7:0]  <= mem_rdata;
          default:    ;
        endcase
      end
      if (m_end_c) halted <= (state_d == S_HALTED);
    end
  end

  assign mcycle = mcyc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small memory, PC register and decode model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_wait;
  logic [15:0] pc, hl;
  logic        pc_inc;
  logic [7:0]  ir;
  logic        cb_prefix;
  logic [2:0]  dec_class;
  logic [1:0]  dec_internal;
  logic [15:0] imm;
  logic        exec_strobe, halted, irq_pending;
  logic [1:0]  tstate;
  logic [2:0]  mcycle;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [7:0]  ir;
    logic        cb;
    logic [15:0] imm;
    int          strobe;
    int          npc;
    int          nrd;
    int          nwr;
    logic        halt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_sequencer #(.T_PER_M(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait), .pc(pc), .hl(hl), .pc_inc(pc_inc),
    .ir(ir), .cb_prefix(cb_prefix), .dec_class(dec_class), .dec_internal(dec_internal),
    .imm(imm), .exec_strobe(exec_strobe), .halted(halted), .irq_pending(irq_pending),
    .tstate(tstate), .mcycle(mcycle)
  );

  assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 16'h0000;
    else if (pc_inc) pc <= pc + 16'h0001;
  end

  // Decode model: just enough of the opcode map for the program below.
  always_comb begin
    dec_class    = 3'd0;
    dec_internal = 2'd0;
    case (ir)
      8'h3E: dec_class = 3'd1;
      8'h21: dec_class = 3'd2;
      8'h7E: dec_class = 3'd3;
      8'h77: dec_class = 3'd4;
      8'h76: dec_class = 3'd5;
      8'hCB: dec_class = 3'd6;
      8'h18: begin dec_class = 3'd1; dec_internal = 2'd1; end
      8'h03: dec_internal = 2'd1;
      8'h36: if (cb_prefix) dec_class = 3'd7;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting at FETCH T0 (called on a negedge); optional wait states.
  task automatic run_instr(input string tag, input logic [7:0] eir, input logic ecb,
                           input logic [15:0] eimm, input int estrobe, input int enpc,
                           input int enrd, input int enwr, input logic ehalt,
                           input int wait_m, input int wait_n);
    exp_t e;
    int idx, got, npc, nrd, nwr, waited;
    logic [15:0] wa;
    e = '{ir: eir, cb: ecb, imm: eimm, strobe: estrobe, npc: enpc, nrd: enrd, nwr: enwr, halt: ehalt};
    sb.push_back(e);
    idx = 0; got = -1; npc = 0; nrd = 0; nwr = 0; waited = 0; wa = 16'h0000;
    while (got < 0 && idx < 64) begin
      mem_wait = (mcycle == 3'(wait_m)) && (tstate == 2'd2) && (waited < wait_n);
      if (mem_wait) waited++;
      if (pc_inc) npc++;
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; wa = mem_addr; end
      if (exec_strobe) got = idx;
      @(posedge clk);
      @(negedge clk);
      idx++;
    end
    mem_wait = 1'b0;
    e = sb.pop_front();
    check({tag, "_strobe_clk"}, 32'(got), 32'(e.strobe));
    check({tag, "_ir"}, 32'(ir), 32'(e.ir));
    check({tag, "_cb"}, 32'(cb_prefix), 32'(e.cb));
    check({tag, "_imm"}, 32'(imm), 32'(e.imm));
    check({tag, "_pc_inc"}, 32'(npc), 32'(e.npc));
    check({tag, "_rd_clks"}, 32'(nrd), 32'(e.nrd));
    check({tag, "_wr_clks"}, 32'(nwr), 32'(e.nwr));
    if (e.nwr != 0) check({tag, "_wr_addr"}, 32'(wa), 32'h0000C000);
    check({tag, "_halted"}, 32'(halted), 32'(e.halt));
    check({tag, "_next_t0"}, {27'd0, mcycle, tstate}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog [26];
    int bad, nstr, k;
    prog = '{8'h00, 8'h3E, 8'h5A, 8'h21, 8'h34, 8'h12, 8'h21, 8'h78, 8'h56,
             8'hCB, 8'h36, 8'h7E, 8'h77, 8'h18, 8'hFE, 8'h03, 8'hCB, 8'hCB,
             8'hCB, 8'h76, 8'h76, 8'h3E, 8'h99, 8'h21, 8'hAA, 8'hBB};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 26; i++) mem[i] = prog[i];
    mem[16'hC000] = 8'hA5;
    hl = 16'hC000;
    mem_wait = 1'b0;
    irq_pending = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tstate", 32'(tstate), 32'd0);
    check("rst_mcycle", 32'(mcycle), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_imm", 32'(imm), 32'd0);
    check("rst_strobes", {27'd0, mem_rd, mem_wr, pc_inc, exec_strobe, halted}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    run_instr("nop",     8'h00, 1'b0, 16'h0000,  3, 1, 2, 0, 1'b0, -1, 0);
    run_instr("ld_a_n",  8'h3E, 1'b0, 16'h005A,  7, 2, 4, 0, 1'b0, -1, 0);
    run_instr("ld_hl",   8'h21, 1'b0, 16'h1234, 11, 3, 6, 0, 1'b0, -1, 0);
    run_instr("ld_hl_w", 8'h21, 1'b0, 16'h5678, 13, 3, 8, 0, 1'b0,  2, 2);
    run_instr("swap_hl", 8'h36, 1'b1, 16'h56A5, 15, 2, 6, 2, 1'b0, -1, 0);
    run_instr("ld_a_hl", 8'h7E, 1'b0, 16'h56A5,  7, 1, 4, 0, 1'b0, -1, 0);
    run_instr("ld_hl_a", 8'h77, 1'b0, 16'h56A5,  7, 1, 2, 2, 1'b0, -1, 0);
    run_instr("jr_n",    8'h18, 1'b0, 16'h00FE, 11, 2, 4, 0, 1'b0, -1, 0);
    run_instr("inc_bc",  8'h03, 1'b0, 16'h00FE,  7, 1, 2, 0, 1'b0, -1, 0);
    run_instr("cb_cb",   8'hCB, 1'b1, 16'h00FE,  7, 2, 4, 0, 1'b0, -1, 0);
    run_instr("cb_76",   8'h76, 1'b1, 16'h00FE,  7, 2, 4, 0, 1'b0, -1, 0);
    run_instr("halt",    8'h76, 1'b0, 16'h00FE,  3, 1, 2, 0, 1'b1, -1, 0);

    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!halted || mem_rd || mem_wr || pc_inc || exec_strobe) bad++;
      @(negedge clk);
    end
    check("halt_idle", 32'(bad), 32'd0);
    k = 0;
    while (tstate != 2'd3 && k < 8) begin @(negedge clk); k++; end
    check("halt_t3_found", 32'(tstate), 32'd3);
    irq_pending = 1'b1;
    @(negedge clk);
    irq_pending = 1'b0;
    check("wake_halted", 32'(halted), 32'd0);
    check("wake_t0", {27'd0, mcycle, tstate}, 32'd0);
    run_instr("post_wake", 8'h3E, 1'b0, 16'h0099, 7, 2, 4, 0, 1'b0, -1, 0);

    nstr = 0;
    k = 0;
    while (!(mcycle == 3'd2 && tstate == 2'd1) && k < 32) begin
      if (exec_strobe) nstr++;
      @(negedge clk);
      k++;
    end
    check("imm_hi_reached", {27'd0, mcycle, tstate}, {27'd0, 3'd2, 2'd1});
    rst_n = 1'b0;
    #1;
    check("mid_rst_tstate", 32'(tstate), 32'd0);
    check("mid_rst_mcycle", 32'(mcycle), 32'd0);
    check("mid_rst_ir", 32'(ir), 32'd0);
    check("mid_rst_imm", 32'(imm), 32'd0);
    check("mid_rst_cb", 32'(cb_prefix), 32'd0);
    check("mid_rst_strobes", {27'd0, mem_rd, mem_wr, pc_inc, exec_strobe, halted}, 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (exec_strobe) nstr++;
    end
    check("rst_no_strobe", 32'(nstr), 32'd0);
    rst_n = 1'b1;
    run_instr("nop_after_rst", 8'h00, 1'b0, 16'h0000, 3, 1, 2, 0, 1'b0, -1, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
